mdu_iterative: RTL
==================

Name: mdu_iterative

Overview:
- Multi-cycle RV32M multiply/divide unit sitting between the register file read ports and its write port.
- Consumes rs1/rs2 operands (read_data1/read_data2) plus funct3 and rd from decode.
- Iterates one bit per cycle and presents a single-cycle writeback request (wb_en, wb_addr, result) that drives the register file's we/addr3/wd.
- The controller stalls the PC while busy is high.

Parameters:
- XLEN, 32, operand and result width. Only 32 is supported.
- CNT_W, 5, width of the iteration counter (log2 XLEN).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-low reset; sampled on rising edge of clk.
- start  input  1  request a new operation; sampled only in IDLE or DONE.
- funct3  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- op_a  input  32  rs1 value (dividend / multiplicand).
- op_b  input  32  rs2 value (divisor / multiplier).
- rd  input  5  destination register index.
- busy  output  1  high while an operation is in CALC.
- done  output  1  one-cycle pulse when result is valid.
- result  output  32  final value; holds until the next done.
- wb_en  output  1  equals done, gated low when wb_addr is 0.
- wb_addr  output  5  latched rd of the completed operation.

Behaviour:
- Reset (rst=0 at a clk edge):
  - state becomes IDLE.
  - busy, done, wb_en become 0; result and wb_addr become 0.
  - Counter and all datapath registers are cleared.
  - Applies in any state; an in-flight operation is discarded with no writeback.
- States:
  - IDLE: on start=1, latch op_a, op_b, funct3 and rd, clear counter, go to CALC.
  - CALC: one iteration per cycle. When counter reaches 31, go to DONE. start is ignored.
  - DONE: done=1 and result is valid.
    - If start=1 in this cycle, the new operation is accepted (back-to-back) and the state goes to CALC.
    - Otherwise the state goes to IDLE.
- Latency:
  - start accepted at edge E0; busy=1 from E0 to E32.
  - done=1 after edge E32 for exactly one cycle, giving 33 cycles from accept to done. The latency is identical for all funct3 values.
- Signedness and preparation in IDLE:
  - op_a is signed for MUL/MULH/MULHSU/DIV/REM.
  - op_b is signed for MUL/MULH/DIV/REM.
  - Magnitudes are taken, and result signs are recorded.
- Multiply:
  - Shift-add on magnitudes into a 64-bit product.
  - In DONE, the 64-bit product is negated if the recorded sign is negative.
  - MUL returns the low 32 bits; MULH, MULHSU and MULHU return the high 32 bits.
- Divide:
  - Restoring, MSB first, on magnitudes.
  - Quotient sign is sign(a) XOR sign(b); remainder sign is sign(a).
- Special cases, resolved in DONE and overriding the iterative result:
  - Divisor 0:
    - DIV/DIVU quotient = 0xFFFFFFFF.
    - REM/REMU return op_a unchanged.
  - Signed overflow (op_a=0x80000000, op_b=0xFFFFFFFF):
    - DIV = 0x80000000.
    - REM = 0.
- Writeback:
  - wb_en = done AND (wb_addr != 0).
  - The register file must never be written for x0.
- Inputs:
  - Operand inputs may change freely after the accept edge; only latched copies are used.
  - start while busy=1 is dropped, not queued.

Test Plan:
- Reset mid-op: start MUL 7×6, assert rst=0 at cycle 10 → busy=0 next cycle, no done/wb_en for 40 cycles, result=0.
- MUL/MULH signed: a=0xFFFFFFFE (-2), b=3, rd=5 → done exactly 33 cycles after accept.
  - MUL result=0xFFFFFFFA with wb_en=1, wb_addr=5.
  - MULH result=0xFFFFFFFF.
  - MULHU result=0x00000002.
- Division signs: DIV -7/2 → 0xFFFFFFFD (-3); REM -7/2 → 0xFFFFFFFF (-1); DIVU 0xFFFFFFF9/2 → 0x7FFFFFFC.
- Corners:
  - DIV 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- Handshake:
  - start held high through CALC → no second accept until DONE.
  - start=1 in the DONE cycle → second op accepted, done pulses 33 cycles later.
  - rd=0 → done=1 with wb_en=0.

Source files
------------

// File: rtl/mdu_iterative_if.sv
// Operand/result bundle between decode/register-file and the iterative RV32M unit.
// The master side issues operations; the slave side (the unit) returns writeback.
interface mdu_iterative_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [4:0]      rd;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;
    logic            wb_en;
    logic [4:0]      wb_addr;

    modport master (
        output start, funct3, op_a, op_b, rd,
        input  busy, done, result, wb_en, wb_addr
    );

    modport slave (
        input  start, funct3, op_a, op_b, rd,
        output busy, done, result, wb_en, wb_addr
    );
endinterface

// File: rtl/mdu_iterative.sv
// Iterative RV32M multiply/divide: one shift-add or restoring-divide step per cycle,
// 33 cycles from accept to a single-cycle writeback request.
module mdu_iterative #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    mdu_iterative_if.slave  bus
);
    localparam logic [2:0] F_MUL    = 3'd0;
    localparam logic [2:0] F_MULH   = 3'd1;
    localparam logic [2:0] F_MULHSU = 3'd2;
    localparam logic [2:0] F_MULHU  = 3'd3;
    localparam logic [2:0] F_DIV    = 3'd4;
    localparam logic [2:0] F_DIVU   = 3'd5;
    localparam logic [2:0] F_REM    = 3'd6;
    localparam logic [2:0] F_REMU   = 3'd7;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t            state_r, state_nx_s;
    logic              accept_s;
    logic [CNT_W-1:0]  cnt_r;
    logic [XLEN-1:0]   hi_r, lo_r, opnd_r, op_a_r;
    logic [2:0]        f3_r;
    logic [4:0]        rd_r;
    logic              sgn_ab_r, sgn_a_r, dz_r, ovf_r;
    logic              busy_r, done_r, wb_en_r;
    logic [XLEN-1:0]   result_r;
    logic [4:0]        wb_addr_r;

    logic              a_signed_s, b_signed_s, sa_s, sb_s;
    logic [XLEN-1:0]   a_mag_s, b_mag_s;
    logic [XLEN:0]     mul_sum_s, div_shift_s;
    logic [XLEN-1:0]   div_diff_s;
    logic              div_ge_s;
    logic [XLEN-1:0]   iter_hi_s, iter_lo_s, final_s;
    logic [2*XLEN-1:0] prod_s;

    function automatic logic [XLEN-1:0] cneg_f(input logic [XLEN-1:0] v, input logic n);
        return n ? ({XLEN{1'b0}} - v) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] cneg2_f(input logic [2*XLEN-1:0] v, input logic n);
        return n ? ({(2*XLEN){1'b0}} - v) : v;
    endfunction

    // Operand signedness and magnitudes for the operation being offered
    always_comb begin
        a_signed_s = 1'b0;
        b_signed_s = 1'b0;
        case (bus.funct3)
            F_MUL, F_MULH, F_DIV, F_REM: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b1;
            end
            F_MULHSU: begin
                a_signed_s = 1'b1;
                b_signed_s = 1'b0;
            end
            default: begin
                a_signed_s = 1'b0;
                b_signed_s = 1'b0;
            end
        endcase
        sa_s    = a_signed_s & bus.op_a[XLEN-1];
        sb_s    = b_signed_s & bus.op_b[XLEN-1];
        a_mag_s = cneg_f(bus.op_a, sa_s);
        b_mag_s = cneg_f(bus.op_b, sb_s);
    end

    // One iteration step and the sign/special-case resolved final value
    always_comb begin
        mul_sum_s   = {1'b0, hi_r} + (lo_r[0] ? {1'b0, opnd_r} : {(XLEN+1){1'b0}});
        div_shift_s = {hi_r, lo_r[XLEN-1]};
        div_ge_s    = (div_shift_s >= {1'b0, opnd_r});
        div_diff_s  = div_shift_s[XLEN-1:0] - opnd_r;
        if (f3_r[2]) begin
            iter_hi_s = div_ge_s ? div_diff_s : div_shift_s[XLEN-1:0];
            iter_lo_s = {lo_r[XLEN-2:0], div_ge_s};
        end else begin
            iter_hi_s = mul_sum_s[XLEN:1];
            iter_lo_s = {mul_sum_s[0], lo_r[XLEN-1:1]};
        end
        prod_s = cneg2_f({iter_hi_s, iter_lo_s}, sgn_ab_r);
        case (f3_r)
            F_MUL:                     final_s = prod_s[XLEN-1:0];
            F_MULH, F_MULHSU, F_MULHU: final_s = prod_s[2*XLEN-1:XLEN];
            F_DIV:   final_s = dz_r ? {XLEN{1'b1}} :
                               (ovf_r ? {1'b1, {(XLEN-1){1'b0}}} : cneg_f(iter_lo_s, sgn_ab_r));
            F_DIVU:  final_s = dz_r ? {XLEN{1'b1}} : iter_lo_s;
            F_REM:   final_s = dz_r ? op_a_r :
                               (ovf_r ? {XLEN{1'b0}} : cneg_f(iter_hi_s, sgn_a_r));
            F_REMU:  final_s = dz_r ? op_a_r : iter_hi_s;
            default: final_s = {XLEN{1'b0}};
        endcase
    end

    // Next-state logic; start is only honoured in IDLE or DONE
    always_comb begin
        state_nx_s = state_r;
        accept_s   = 1'b0;
        case (state_r)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_nx_s = CALC;
                    accept_s   = 1'b1;
                end else begin
                    state_nx_s = IDLE;
                    accept_s   = 1'b0;
                end
            end
            CALC: begin
                if (cnt_r == {CNT_W{1'b1}}) begin
                    state_nx_s = DONE;
                end else begin
                    state_nx_s = CALC;
                end
            end
            default: begin
                state_nx_s = IDLE;
                accept_s   = 1'b0;
            end
        endcase
    end

    // State register and registered handshake outputs
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            wb_en_r <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s == CALC);
            done_r  <= (state_nx_s == DONE);
            wb_en_r <= (state_nx_s == DONE) && (rd_r != 5'd0);
        end
    end

    // Operand latch on accept, then one iteration per CALC cycle
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= {XLEN{1'b0}};
            opnd_r   <= {XLEN{1'b0}};
            op_a_r   <= {XLEN{1'b0}};
            f3_r     <= 3'd0;
            rd_r     <= 5'd0;
            sgn_ab_r <= 1'b0;
            sgn_a_r  <= 1'b0;
            dz_r     <= 1'b0;
            ovf_r    <= 1'b0;
        end else if (accept_s) begin
            cnt_r    <= {CNT_W{1'b0}};
            hi_r     <= {XLEN{1'b0}};
            lo_r     <= bus.funct3[2] ? a_mag_s : b_mag_s;
            opnd_r   <= bus.funct3[2] ? b_mag_s : a_mag_s;
            op_a_r   <= bus.op_a;
            f3_r     <= bus.funct3;
            rd_r     <= bus.rd;
            sgn_ab_r <= sa_s ^ sb_s;
            sgn_a_r  <= sa_s;
            dz_r     <= (bus.op_b == {XLEN{1'b0}});
            ovf_r    <= a_signed_s && b_signed_s &&
                        (bus.op_a == {1'b1, {(XLEN-1){1'b0}}}) && (bus.op_b == {XLEN{1'b1}});
        end else if (state_r == CALC) begin
            cnt_r <= cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
            hi_r  <= iter_hi_s;
            lo_r  <= iter_lo_s;
        end
    end

    // Result and destination captured on the final iteration, held until the next one
    always_ff @(posedge clk) begin
        if (!rst) begin
            result_r  <= {XLEN{1'b0}};
            wb_addr_r <= 5'd0;
        end else if ((state_r == CALC) && (state_nx_s == DONE)) begin
            result_r  <= final_s;
            wb_addr_r <= rd_r;
        end
    end

    assign bus.busy    = busy_r;
    assign bus.done    = done_r;
    assign bus.wb_en   = wb_en_r;
    assign bus.result  = result_r;
    assign bus.wb_addr = wb_addr_r;
endmodule
